// File: rtl/dpm_arb_pkg.sv
// Shared constants and the command record for the dual-port memory arbiter.
// Command fields are sized for the widest supported build; the top slices them down.
package dpm_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int WIDTH_DEF   = 12;
  localparam int ADDR_DEF    = 10;
  localparam int CMD_ADDR_W  = 32;
  localparam int CMD_DATA_W  = 64;
  localparam int ID_W        = 3;

  typedef struct packed {
    logic                  we;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
    logic [ID_W-1:0]       id;
  } cmd_t;

  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx, input int n);
    return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/dpm_arbiter_if.sv
// Requester-side bundle of the arbiter: request handshake plus read responses.
interface dpm_arbiter_if
  import dpm_arb_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int ADDR    = ADDR_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input logic i_clk
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_we;
  logic [NUM_REQ*ADDR-1:0]  req_addr;
  logic [NUM_REQ*WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ*WIDTH-1:0] rsp_data;

  modport master (
    input  i_clk,
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  i_clk,
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/dpm_rr_pick.sv
// Round-robin picker: first set bit of mask at or after ptr, as one-hot and index.
module dpm_rr_pick
  import dpm_arb_pkg::*;
#(
  parameter int N = NUM_REQ_DEF
) (
  input  logic [N-1:0]    mask,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            found
);

  int best;
  int sel;

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    best  = N;
    sel   = 0;
    grant = '0;
    for (int j = 0; j < N; j++) begin
      if (mask[j] && (((j - int'(ptr) + N) % N) < best)) begin
        best = (j - int'(ptr) + N) % N;
        sel  = j;
      end
    end
    found = (best < N);
    for (int j = 0; j < N; j++) begin
      if (found && (sel == j)) grant[j] = 1'b1;
    end
    idx = ID_W'(sel);
  end

endmodule

// File: rtl/dpm_arbiter.sv
// Arbitrates NUM_REQ requesters onto the two ports of a synchronous dual-port RAM,
// two grants per cycle, with read responses returned two cycles after the handshake.
module dpm_arbiter
  import dpm_arb_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int ADDR    = ADDR_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ-1:0]       i_req_we,
  input  logic [NUM_REQ*ADDR-1:0]  i_req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic [NUM_REQ-1:0]       o_rsp_valid,
  output logic [NUM_REQ*WIDTH-1:0] o_rsp_data,
  output logic                     o_en_a,
  output logic                     o_we_a,
  output logic [ADDR-1:0]          o_addr_a,
  output logic [WIDTH-1:0]         o_din_a,
  input  logic [WIDTH-1:0]         i_dout_a,
  output logic                     o_en_b,
  output logic                     o_we_b,
  output logic [ADDR-1:0]          o_addr_b,
  output logic [WIDTH-1:0]         o_din_b,
  input  logic [WIDTH-1:0]         i_dout_b,
  output logic [15:0]              o_conflict_cnt
);

  logic [NUM_REQ-1:0] gnt_a, gnt_b, grant;
  logic [ID_W-1:0]    idx_a, idx_b, rr_ptr_q, rr_next;
  logic               fnd_a, fnd_b, conflict, take_b;
  cmd_t               cmd_a_d, cmd_b_d, cmd_a_q, cmd_b_q;
  logic               en_a_q, en_b_q;
  logic               rd_a_q, rd_b_q;
  logic [ID_W-1:0]    rd_id_a_q, rd_id_b_q;
  logic [15:0]        cnt_q;
  logic               spare_unused;

  dpm_rr_pick #(.N(NUM_REQ)) u_pick_a (
    .mask  (i_req_valid),
    .ptr   (rr_ptr_q),
    .grant (gnt_a),
    .idx   (idx_a),
    .found (fnd_a)
  );

  // Port B searches from the same pointer with port A's winner removed.
  dpm_rr_pick #(.N(NUM_REQ)) u_pick_b (
    .mask  (i_req_valid & ~gnt_a),
    .ptr   (rr_ptr_q),
    .grant (gnt_b),
    .idx   (idx_b),
    .found (fnd_b)
  );

  always_comb begin
    cmd_a_d = '0;
    cmd_b_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_a[i]) begin
        cmd_a_d.we               = i_req_we[i];
        cmd_a_d.addr[ADDR-1:0]   = i_req_addr[i*ADDR +: ADDR];
        cmd_a_d.wdata[WIDTH-1:0] = i_req_wdata[i*WIDTH +: WIDTH];
        cmd_a_d.id               = ID_W'(i);
      end
      if (gnt_b[i]) begin
        cmd_b_d.we               = i_req_we[i];
        cmd_b_d.addr[ADDR-1:0]   = i_req_addr[i*ADDR +: ADDR];
        cmd_b_d.wdata[WIDTH-1:0] = i_req_wdata[i*WIDTH +: WIDTH];
        cmd_b_d.id               = ID_W'(i);
      end
    end
    // A read pair may share an address; any write involvement defers port B.
    conflict = fnd_b && (cmd_a_d.addr == cmd_b_d.addr) && (cmd_a_d.we || cmd_b_d.we);
    take_b   = fnd_b && !conflict;
    grant    = gnt_a | (take_b ? gnt_b : '0);
    if (take_b)     rr_next = next_idx(idx_b, NUM_REQ);
    else if (fnd_a) rr_next = next_idx(idx_a, NUM_REQ);
    else            rr_next = rr_ptr_q;
  end

  assign o_req_ready = i_rst_n ? grant : '0;

  // NOTE: sequential state is assigned with non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_q  <= '0;
      en_a_q    <= 1'b0;
      en_b_q    <= 1'b0;
      cmd_a_q   <= '0;
      cmd_b_q   <= '0;
      rd_a_q    <= 1'b0;
      rd_b_q    <= 1'b0;
      rd_id_a_q <= '0;
      rd_id_b_q <= '0;
      cnt_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_next;
      en_a_q    <= fnd_a;
      cmd_a_q   <= cmd_a_d;
      en_b_q    <= take_b;
      cmd_b_q   <= take_b ? cmd_b_d : '0;
      rd_a_q    <= en_a_q && !cmd_a_q.we;
      rd_b_q    <= en_b_q && !cmd_b_q.we;
      rd_id_a_q <= cmd_a_q.id;
      rd_id_b_q <= cmd_b_q.id;
      if (conflict && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign o_en_a         = en_a_q;
  assign o_we_a         = cmd_a_q.we;
  assign o_addr_a       = cmd_a_q.addr[ADDR-1:0];
  assign o_din_a        = cmd_a_q.wdata[WIDTH-1:0];
  assign o_en_b         = en_b_q;
  assign o_we_b         = cmd_b_q.we;
  assign o_addr_b       = cmd_b_q.addr[ADDR-1:0];
  assign o_din_b        = cmd_b_q.wdata[WIDTH-1:0];
  assign o_conflict_cnt = cnt_q;

  // Spare high bits of the wide command record are folded away here.
  assign spare_unused = ^{cmd_a_q.addr, cmd_a_q.wdata, cmd_b_q.addr, cmd_b_q.wdata};

  // RAM output is valid in the cycle after the memory access; route it to the owner.
  always_comb begin
    o_rsp_valid = '0;
    o_rsp_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd_a_q && (rd_id_a_q == ID_W'(i))) begin
        o_rsp_valid[i]                = 1'b1;
        o_rsp_data[i*WIDTH +: WIDTH] = i_dout_a;
      end else if (rd_b_q && (rd_id_b_q == ID_W'(i))) begin
        o_rsp_valid[i]                = 1'b1;
        o_rsp_data[i*WIDTH +: WIDTH] = i_dout_b;
      end
    end
  end

endmodule

// File: doc/dpm_arbiter.md
DPM_ARBITER -- requirements
Module: dpm_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 12, memory data width.
REQ-002 SHALL have parameter ADDR, default 10, memory address width.
REQ-003 SHALL have parameter NUM_REQ, default 4, requester count (2..8).
REQ-004 SHALL have ports i_clk (in, 1), the single clock, and i_rst_n (in, 1), asynchronous active-low reset.
REQ-005 SHALL have ports i_req_valid (in, NUM_REQ), i_req_we (in, NUM_REQ), i_req_addr (in, NUM_REQ*ADDR) and i_req_wdata (in, NUM_REQ*WIDTH); slot i is bits [i*W +: W].
REQ-006 SHALL have ports o_req_ready (out, NUM_REQ), o_rsp_valid (out, NUM_REQ) and o_rsp_data (out, NUM_REQ*WIDTH).
REQ-007 SHALL have memory ports o_en_a, o_we_a (out, 1), o_addr_a (out, ADDR), o_din_a (out, WIDTH) and i_dout_a (in, WIDTH), plus the identical _b set; both memory clocks tie to i_clk.
REQ-008 SHALL have port o_conflict_cnt (out, 16), the saturating count of deferred conflicts.

Function
REQ-009 SHALL select at most two requesters per cycle by round-robin starting at rr_ptr: first valid → port A, next valid → port B.
REQ-010 SHALL drive o_req_ready combinationally, high only for granted requesters; transfer = valid & ready.
REQ-011 SHALL defer the port-B candidate when its address equals port A's and either is a write (pair of reads to the same address allowed); deferred requester gets no ready and no other requester replaces it that cycle; o_conflict_cnt +1, saturating at 0xFFFF.
REQ-012 SHALL register granted commands at the handshake edge and present them on the memory ports the next cycle (en=1, we, addr, din); idle port holds en=0, we=0.
REQ-013 SHALL assert o_rsp_valid[i] for exactly one cycle, two cycles after a read handshake cycle, with o_rsp_data slot i = i_dout of the serving port.
REQ-014 SHALL produce no response for writes.
REQ-015 SHALL hold requester order: back-to-back reads from one requester return in issue order, one per cycle.
REQ-016 SHALL allow a requester two consecutive grants in one cycle only via separate cycles; one requester never holds both ports at once.
REQ-017 SHALL update rr_ptr to (last granted index + 1) mod NUM_REQ; rr_ptr SHALL be unchanged with no grant; wrap NUM_REQ-1 → 0.
REQ-018 SHALL have no response backpressure; requesters SHALL accept o_rsp_valid unconditionally.

Reset
REQ-019 SHALL, with i_rst_n low, clear asynchronously: rr_ptr=0, command registers (en/we=0, addr/din=0), pending-read tags, o_rsp_valid=0, o_rsp_data=0, o_conflict_cnt=0; o_req_ready=0 while in reset.
REQ-020 SHALL drop in-flight reads on reset mid-operation and issue no response for them after release.
REQ-021 SHALL accept requests on the first rising edge after deassertion.

Structure
REQ-022 SHALL place in package dpm_arb_pkg: the command struct typedef (we, addr, wdata, requester id) and the NUM_REQ default constant.
REQ-023 SHALL implement round-robin selection in sub-module dpm_rr_pick (mask + pointer → one-hot grant), instantiated twice (second instance masks the first grant).

Verification
REQ-024 SHALL verify: all 4 requesters read distinct addresses 0x010..0x013, rr_ptr=0 → cycle 0 grants req0/A and req1/B, cycle 1 grants req2/A and req3/B; each rsp 2 cycles after its handshake with the preloaded data.
REQ-025 SHALL verify: req0 writes 0x0AB to 0x005 while req1 reads 0x005 → req1 deferred, o_conflict_cnt=1; req1 next cycle reads 0x0AB.
REQ-026 SHALL verify: req2 and req3 both read 0x3FF → both granted the same cycle, no conflict count, both responses 2 cycles later.
REQ-027 SHALL verify: only req3 valid, rr_ptr=3 → req3 granted on A; rr_ptr wraps to 0.
REQ-028 SHALL verify: reset pulsed the cycle after a read handshake → no o_rsp_valid afterward, all outputs zero, and a new read after release returns correctly.
REQ-029 SHALL verify: forced 70000 conflicts → o_conflict_cnt holds 0xFFFF.
